data_mem: RTL and testbench
===========================

DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes occur on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port req_valid, input, 1 bit: request present.
REQ-004 SHALL have port req_ready, output, 1 bit: block can accept a request.
REQ-005 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-006 SHALL have port req_addr, input, `CPU_WIDTH bits: byte address.
REQ-007 SHALL have port req_size, input, 2 bits: 00 byte, 01 half, 10 word, 11 illegal.
REQ-008 SHALL have port req_unsigned, input, 1 bit: zero-extend loads when 1, sign-extend when 0.
REQ-009 SHALL have port req_wdata, input, `CPU_WIDTH bits: store data, right-aligned.
REQ-010 SHALL have port resp_valid, output, 1 bit: response present.
REQ-011 SHALL have port resp_ready, input, 1 bit: consumer takes the response.
REQ-012 SHALL have port resp_rdata, output, `CPU_WIDTH bits: extended load data; 0 for stores and errors.
REQ-013 SHALL have port resp_err, output, 1 bit: access faulted.
REQ-014 SHALL have ports mem0..mem35, output, `CPU_BYTE bits each: live contents of bytes 0..35, which feed the word-assembly checker.

Function
REQ-015 SHALL hold 64 bytes of storage; addresses with req_addr[31:6] != 0 are out of range.
REQ-016 SHALL store big-endian: the byte at address A is bits [31:24] of the word at A; a half at A occupies bytes A (MSB) and A+1.
REQ-017 SHALL implement a two-state FSM: IDLE (req_ready=1, resp_valid=0) and RESP (req_ready=0, resp_valid=1).
REQ-018 SHALL accept a request on a rising edge with req_valid=1 in IDLE, then move to RESP on that same edge.
REQ-019 SHALL, on acceptance of a legal store, write the low 1/2/4 bytes of req_wdata on that same edge; mem0..mem35 reflect the update one cycle after acceptance.
REQ-020 SHALL, on acceptance of a legal load, register the extended data into resp_rdata; latency is 1 cycle from acceptance to resp_valid.
REQ-021 SHALL hold resp_rdata and resp_err stable while in RESP; it returns to IDLE on the edge where resp_ready=1.
REQ-022 SHALL accept no new request in the cycle the response is consumed; back-to-back throughput is one access per 2 cycles.
REQ-023 SHALL treat the following as errors: out-of-range address, or req_size=11; an error sets resp_err=1, resp_rdata=0 and performs no write.
REQ-024 SHALL make no change to any state when req_valid=0 in IDLE; resp_ready is ignored in IDLE.

Reset
REQ-025 SHALL, when rst_n=0, immediately force: state IDLE, resp_valid=0, resp_rdata=0, resp_err=0, and all 64 bytes to 0, so that mem0..mem35 read 0.
REQ-026 SHALL, if reset asserts in RESP, drop the pending response; a store accepted before reset is also cleared by the reset.

Configuration
REQ-027 SHALL have macro MISALIGN_TRAP_EN: when defined, a half at an odd address or a word with addr[1:0] != 0 is an error (REQ-023 handling applies).
REQ-028 SHALL, when MISALIGN_TRAP_EN is undefined, align a misaligned access down (forcing addr[0] for half, or addr[1:0] for word, to 0) and execute it with resp_err=0.

Verification
REQ-029 SHALL cover this scenario: store word 0x11223344 at address 0 -> one cycle later mem0..mem3 = 11,22,33,44; resp_err=0, resp_rdata=0.
REQ-030 SHALL cover this scenario: with bytes 4..7 = 80,01,FF,02, a signed load half at address 4 -> resp_rdata=0xFFFF8001; an unsigned load byte at address 6 -> 0x000000FF.
REQ-031 SHALL cover this scenario: load word at address 0x40 -> resp_err=1, resp_rdata=0; a store at 0x40 changes no byte.
REQ-032 SHALL cover this scenario: store word 0xAABBCCDD at address 0x22. With MISALIGN_TRAP_EN defined: resp_err=1 and bytes 32..35 are unchanged. Without it: bytes 32..35 = AA,BB,CC,DD.
REQ-033 SHALL cover this scenario: hold resp_ready=0 for 5 cycles after a load -> resp_valid and resp_rdata hold constant and req_ready=0 throughout; one edge after resp_ready=1, req_ready=1.
REQ-034 SHALL cover this scenario: assert rst_n=0 mid-cycle while in RESP after a store of 0xFF to byte 35 -> resp_valid=0 and mem35=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/data_mem.sv
// data_mem -- 64-byte big-endian data memory with a valid/ready request and
// response handshake.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_ready : request handshake (ready only while IDLE)
//   req_we              : 1 = store, 0 = load
//   req_addr            : byte address; anything at or above 64 faults
//   req_size            : 00 byte, 01 half, 10 word, 11 illegal (faults)
//   req_unsigned        : zero-extend loads when 1, sign-extend when 0
//   req_wdata           : store data, right-aligned
//   resp_valid/ready    : response handshake (valid only while RESP)
//   resp_rdata          : extended load data, 0 for stores and faults
//   resp_err            : access faulted
//   mem0..mem35         : live contents of bytes 0..35
//
// Configuration macro MISALIGN_TRAP_EN: when defined, a misaligned half or
// word faults. When undefined, the address is aligned down and the access
// proceeds without a fault.

`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef CPU_BYTE
`define CPU_BYTE 8
`endif

module data_mem (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [`CPU_WIDTH-1:0]  req_addr,
  input  logic [1:0]             req_size,
  input  logic                   req_unsigned,
  input  logic [`CPU_WIDTH-1:0]  req_wdata,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [`CPU_WIDTH-1:0]  resp_rdata,
  output logic                   resp_err,
  output logic [`CPU_BYTE-1:0]   mem0,  mem1,  mem2,  mem3,  mem4,  mem5,
  output logic [`CPU_BYTE-1:0]   mem6,  mem7,  mem8,  mem9,  mem10, mem11,
  output logic [`CPU_BYTE-1:0]   mem12, mem13, mem14, mem15, mem16, mem17,
  output logic [`CPU_BYTE-1:0]   mem18, mem19, mem20, mem21, mem22, mem23,
  output logic [`CPU_BYTE-1:0]   mem24, mem25, mem26, mem27, mem28, mem29,
  output logic [`CPU_BYTE-1:0]   mem30, mem31, mem32, mem33, mem34, mem35
);

  localparam int W     = `CPU_WIDTH;
  localparam int B     = `CPU_BYTE;
  localparam int DEPTH = 64;

  typedef enum logic {IDLE, RESP} state_t;

  state_t         state_reg;
  logic [B-1:0]   mem_reg [DEPTH];

  logic           accept;
  logic           addr_oor;
  logic           size_bad;
  logic           misalign;
  logic           err;
  logic [5:0]     eff_addr;
  logic [2:0]     nbytes;
  logic [31:0]    wdata_shift;
  logic [31:0]    raw_word;
  logic [W-1:0]   load_data;
  logic [DEPTH-1:0] byte_we;
  logic [B-1:0]   byte_wdata [DEPTH];

  assign req_ready  = (state_reg == IDLE);
  assign resp_valid = (state_reg == RESP);
  assign accept     = (state_reg == IDLE) && req_valid;

  assign addr_oor = |req_addr[W-1:6];
  assign size_bad = (req_size == 2'b11);

`ifdef MISALIGN_TRAP_EN
  assign misalign = ((req_size == 2'b01) && req_addr[0]) ||
                    ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
  assign eff_addr = req_addr[5:0];
`else
  assign misalign = 1'b0;
  always_comb begin
    eff_addr = req_addr[5:0];
    if (req_size == 2'b01) eff_addr[0]   = 1'b0;
    if (req_size == 2'b10) eff_addr[1:0] = 2'b00;
  end
`endif

  assign err = addr_oor | size_bad | misalign;

  // Store data is left-justified so the byte at offset k from the access
  // address always comes from lane (3-k), matching big-endian order.
  always_comb begin
    nbytes      = 3'd4;
    wdata_shift = req_wdata[31:0];
    case (req_size)
      2'b00: begin
        nbytes      = 3'd1;
        wdata_shift = {req_wdata[7:0], 24'h0};
      end
      2'b01: begin
        nbytes      = 3'd2;
        wdata_shift = {req_wdata[15:0], 16'h0};
      end
      default: begin
        nbytes      = 3'd4;
        wdata_shift = req_wdata[31:0];
      end
    endcase
  end

  // Per-byte write decode: a byte is written when it lies within the access
  // window starting at eff_addr.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_byte
      logic [5:0] off;
      assign off            = 6'(gi) - eff_addr;
      assign byte_we[gi]    = accept && req_we && !err && (off < {3'b000, nbytes});
      assign byte_wdata[gi] = wdata_shift[{2'd3 - off[1:0], 3'b000} +: 8];
    end
  endgenerate

  // The 6-bit index wrap only touches lanes a narrower load discards.
  assign raw_word = {mem_reg[eff_addr],         mem_reg[eff_addr + 6'd1],
                     mem_reg[eff_addr + 6'd2],  mem_reg[eff_addr + 6'd3]};

  always_comb begin
    case (req_size)
      2'b00:   load_data = req_unsigned ? {{(W-8){1'b0}}, raw_word[31:24]}
                                        : {{(W-8){raw_word[31]}}, raw_word[31:24]};
      2'b01:   load_data = req_unsigned ? {{(W-16){1'b0}}, raw_word[31:16]}
                                        : {{(W-16){raw_word[31]}}, raw_word[31:16]};
      default: load_data = raw_word;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (byte_we[i]) mem_reg[i] <= byte_wdata[i];
      end
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            state_reg  <= RESP;
            resp_err   <= err;
            resp_rdata <= (err || req_we) ? '0 : load_data;
          end
        end
        RESP: begin
          // Response fields stay frozen until the consumer takes them.
          if (resp_ready) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign mem0  = mem_reg[0];   assign mem1  = mem_reg[1];   assign mem2  = mem_reg[2];
  assign mem3  = mem_reg[3];   assign mem4  = mem_reg[4];   assign mem5  = mem_reg[5];
  assign mem6  = mem_reg[6];   assign mem7  = mem_reg[7];   assign mem8  = mem_reg[8];
  assign mem9  = mem_reg[9];   assign mem10 = mem_reg[10];  assign mem11 = mem_reg[11];
  assign mem12 = mem_reg[12];  assign mem13 = mem_reg[13];  assign mem14 = mem_reg[14];
  assign mem15 = mem_reg[15];  assign mem16 = mem_reg[16];  assign mem17 = mem_reg[17];
  assign mem18 = mem_reg[18];  assign mem19 = mem_reg[19];  assign mem20 = mem_reg[20];
  assign mem21 = mem_reg[21];  assign mem22 = mem_reg[22];  assign mem23 = mem_reg[23];
  assign mem24 = mem_reg[24];  assign mem25 = mem_reg[25];  assign mem26 = mem_reg[26];
  assign mem27 = mem_reg[27];  assign mem28 = mem_reg[28];  assign mem29 = mem_reg[29];
  assign mem30 = mem_reg[30];  assign mem31 = mem_reg[31];  assign mem32 = mem_reg[32];
  assign mem33 = mem_reg[33];  assign mem34 = mem_reg[34];  assign mem35 = mem_reg[35];

endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem -- self-checking bench for data_mem: directed scenarios then
// randomized accesses checked against a byte-array reference model.

`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef CPU_BYTE
`define CPU_BYTE 8
`endif

module tb_data_mem;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [7:0]  mem_o [36];

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] ref_mem [64];

  data_mem dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem0(mem_o[0]),   .mem1(mem_o[1]),   .mem2(mem_o[2]),   .mem3(mem_o[3]),
    .mem4(mem_o[4]),   .mem5(mem_o[5]),   .mem6(mem_o[6]),   .mem7(mem_o[7]),
    .mem8(mem_o[8]),   .mem9(mem_o[9]),   .mem10(mem_o[10]), .mem11(mem_o[11]),
    .mem12(mem_o[12]), .mem13(mem_o[13]), .mem14(mem_o[14]), .mem15(mem_o[15]),
    .mem16(mem_o[16]), .mem17(mem_o[17]), .mem18(mem_o[18]), .mem19(mem_o[19]),
    .mem20(mem_o[20]), .mem21(mem_o[21]), .mem22(mem_o[22]), .mem23(mem_o[23]),
    .mem24(mem_o[24]), .mem25(mem_o[25]), .mem26(mem_o[26]), .mem27(mem_o[27]),
    .mem28(mem_o[28]), .mem29(mem_o[29]), .mem30(mem_o[30]), .mem31(mem_o[31]),
    .mem32(mem_o[32]), .mem33(mem_o[33]), .mem34(mem_o[34]), .mem35(mem_o[35])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_mem(input string tag);
    logic [287:0] obs;
    logic [287:0] exp;
    for (int i = 0; i < 36; i++) begin
      obs[i*8 +: 8] = mem_o[i];
      exp[i*8 +: 8] = ref_mem[i];
    end
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s mem0..35: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference model: byte array, big-endian, computed from the access rules.
  task automatic model(input bit we, input logic [31:0] addr, input logic [1:0] size,
                       input bit uns, input logic [31:0] wdata,
                       output bit e_err, output logic [31:0] e_rdata);
    int     n;
    longint a;
    longint v;
    n       = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    e_err   = (addr >= 64) || (size == 2'd3);
    e_rdata = 32'h0;
    a       = longint'(addr);
`ifdef MISALIGN_TRAP_EN
    if (!e_err && (a % n) != 0) e_err = 1'b1;
`else
    a = a - (a % n);
`endif
    if (e_err) return;
    if (we) begin
      for (int i = 0; i < n; i++)
        ref_mem[int'(a) + i] = 8'((wdata >> (8 * (n - 1 - i))) & 32'hFF);
    end else begin
      v = 0;
      for (int i = 0; i < n; i++) v = v * 256 + longint'(ref_mem[int'(a) + i]);
      if (!uns && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
      e_rdata = 32'(v);
    end
  endtask

  // One full transaction: accept, optional stall with a competing request
  // held on the bus, then consume.
  task automatic access(input bit we, input logic [31:0] addr, input logic [1:0] size,
                        input bit uns, input logic [31:0] wdata, input int hold,
                        input string tag);
    bit          e_err;
    logic [31:0] e_rdata;
    @(negedge clk);
    check({tag, " req_ready idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wdata;
    @(posedge clk); #1;
    model(we, addr, size, uns, wdata, e_err, e_rdata);
    req_valid = 1'b1; req_we = 1'b1; req_addr = $urandom_range(0, 63);
    req_size = 2'($urandom_range(0, 2)); req_wdata = $urandom;
    check({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
    check({tag, " req_ready busy"}, 32'(req_ready), 32'd0);
    check({tag, " resp_err"}, 32'(resp_err), 32'(e_err));
    check({tag, " resp_rdata"}, resp_rdata, e_rdata);
    check_mem(tag);
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      check({tag, " hold resp_valid"}, 32'(resp_valid), 32'd1);
      check({tag, " hold req_ready"}, 32'(req_ready), 32'd0);
      check({tag, " hold resp_rdata"}, resp_rdata, e_rdata);
      check({tag, " hold resp_err"}, 32'(resp_err), 32'(e_err));
    end
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    check({tag, " done resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, " done req_ready"}, 32'(req_ready), 32'd1);
    check_mem({tag, " after"});
    $display("txn %s we=%0d addr=%h size=%0d uns=%0d wdata=%h -> err=%0d rdata=%h",
             tag, we, addr, size, uns, wdata, resp_err, resp_rdata);
  endtask

  initial begin
    bit          r_we;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    bit          r_uns;
    logic [31:0] r_wdata;
    bit          e_err;
    logic [31:0] e_rdata;

    for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0;
    req_unsigned = 1'b0; req_wdata = '0; resp_ready = 1'b0;
    #1;
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset resp_valid", 32'(resp_valid), 32'd0);
    check("reset resp_rdata", resp_rdata, 32'h0);
    check("reset resp_err", 32'(resp_err), 32'd0);
    check_mem("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Store word, big-endian layout.
    access(1'b1, 32'h0, 2'd2, 1'b0, 32'h11223344, 0, "s029_store");
    check("s029 mem0..3", {mem_o[0], mem_o[1], mem_o[2], mem_o[3]}, 32'h11223344);

    // Extended loads.
    access(1'b1, 32'h4, 2'd2, 1'b0, 32'h8001FF02, 0, "s030_init");
    access(1'b0, 32'h4, 2'd1, 1'b0, 32'h0, 0, "s030_lh");
    access(1'b0, 32'h6, 2'd0, 1'b1, 32'h0, 0, "s030_lbu");

    // Out-of-range accesses.
    access(1'b0, 32'h40, 2'd2, 1'b0, 32'h0, 0, "s031_lw");
    access(1'b1, 32'h40, 2'd2, 1'b0, 32'hDEADBEEF, 0, "s031_sw");

    // Misaligned word store.
    access(1'b1, 32'h22, 2'd2, 1'b0, 32'hAABBCCDD, 0, "s032_sw");
`ifdef MISALIGN_TRAP_EN
    check("s032 bytes32..35", {mem_o[32], mem_o[33], mem_o[34], mem_o[35]}, 32'h0);
`else
    check("s032 bytes32..35", {mem_o[32], mem_o[33], mem_o[34], mem_o[35]}, 32'hAABBCCDD);
`endif

    // Stalled response.
    access(1'b0, 32'h4, 2'd2, 1'b0, 32'h0, 5, "s033_stall");

    // Idle cycles with resp_ready high and no request change nothing.
    @(negedge clk);
    resp_ready = 1'b1; req_we = 1'b1; req_addr = 32'h1; req_wdata = 32'hFFFFFFFF;
    repeat (2) @(posedge clk);
    #1;
    check("idle resp_valid", 32'(resp_valid), 32'd0);
    check("idle req_ready", 32'(req_ready), 32'd1);
    check_mem("idle");
    resp_ready = 1'b0;

    // Asynchronous reset while a store response is pending.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'd35; req_size = 2'd0; req_wdata = 32'hFF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("s034 mem35 written", 32'(mem_o[35]), 32'hFF);
    check("s034 resp_valid", 32'(resp_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
    check("s034 resp_valid async", 32'(resp_valid), 32'd0);
    check("s034 mem35 async", 32'(mem_o[35]), 32'h0);
    check_mem("s034");
    $display("txn s034_reset mem35=%h resp_valid=%0d", mem_o[35], resp_valid);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic.
    for (int t = 0; t < 300; t++) begin
      r_we    = 1'($urandom_range(0, 1));
      r_addr  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 71));
      r_size  = 2'($urandom_range(0, 3));
      r_uns   = 1'($urandom_range(0, 1));
      r_wdata = $urandom;
      access(r_we, r_addr, r_size, r_uns, r_wdata, $urandom_range(0, 2), "rand");
    end

    // Sweep every byte back out so bytes 36..63 are checked too.
    for (int a = 0; a < 64; a += 4) begin
      model(1'b0, 32'(a), 2'd2, 1'b0, 32'h0, e_err, e_rdata);
      access(1'b0, 32'(a), 2'd2, 1'b0, 32'h0, 0, "sweep");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
